// File: rtl/tlul_pkg.sv
// TL-UL types, defaults and sizing helpers shared by the socket and its error responder.
package tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_DBW = TL_DW / 8;

  // Widest fanout a single socket is expected to serve.
  localparam int unsigned MAX_SOCKET_FANOUT = 16;

  // Read data returned by the error responder for a Get.
  localparam logic [TL_DW-1:0] TL_ERR_RDATA = '1;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  localparam tl_h2d_t TL_H2D_DEFAULT = '{
    a_valid:   1'b0,
    a_opcode:  Get,
    a_param:   3'h0,
    a_size:    '0,
    a_source:  '0,
    a_address: '0,
    a_mask:    '0,
    a_data:    '0,
    d_ready:   1'b1
  };

  localparam tl_d2h_t TL_D2H_DEFAULT = '{
    d_valid:  1'b0,
    d_opcode: AccessAck,
    d_param:  3'h0,
    d_size:   '0,
    d_source: '0,
    d_sink:   '0,
    d_data:   '0,
    d_error:  1'b0,
    a_ready:  1'b1
  };

  // Bits needed to index 'value' distinct items (at least one bit).
  function automatic int unsigned vbits(input int unsigned value);
    return (value <= 32'd1) ? 32'd1 : unsigned'($clog2(value));
  endfunction

endpackage

// File: rtl/tlul_err_resp.sv
// Error responder: answers any request with d_error set, one transaction at a time.
module tlul_err_resp
  import tlul_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h_i,
  output tl_d2h_t tl_h_o
);

  logic              r_pending;
  logic              r_is_get;
  logic [TL_AIW-1:0] r_source;
  logic [TL_SZW-1:0] r_size;
  logic              w_accept;
  logic              w_unused;

  assign w_accept = tl_h_i.a_valid & ~r_pending;
  assign w_unused = ^{tl_h_i.a_param, tl_h_i.a_address, tl_h_i.a_mask, tl_h_i.a_data};

  // Latch the request identity on accept; release once the host takes the response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending <= 1'b0;
      r_is_get  <= 1'b0;
      r_source  <= '0;
      r_size    <= '0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
      r_is_get  <= (tl_h_i.a_opcode == Get);
      r_source  <= tl_h_i.a_source;
      r_size    <= tl_h_i.a_size;
    end else if (r_pending && tl_h_i.d_ready) begin
      r_pending <= 1'b0;
    end
  end

  // Build the response purely from registered state; anything not a Get is acked as a Put.
  always_comb begin
    tl_h_o          = TL_D2H_DEFAULT;
    tl_h_o.d_valid  = r_pending;
    tl_h_o.d_opcode = r_is_get ? AccessAckData : AccessAck;
    tl_h_o.d_size   = r_size;
    tl_h_o.d_source = r_source;
    tl_h_o.d_data   = r_is_get ? TL_ERR_RDATA : '0;
    tl_h_o.d_error  = 1'b1;
    tl_h_o.a_ready  = ~r_pending;
  end

endmodule

// File: rtl/tlul_socket_1n.sv
// 1-to-N TL-UL socket: steers requests by an external select and returns responses in order.
module tlul_socket_1n
  import tlul_pkg::*;
#(
  parameter int unsigned N              = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned NWD            = vbits(N + 1),
  parameter int unsigned CntW           = vbits(MaxOutstanding + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  tl_h2d_t        tl_h_i,
  output tl_d2h_t        tl_h_o,
  output tl_h2d_t        tl_d_o [N],
  input  tl_d2h_t        tl_d_i [N],
  input  logic [NWD-1:0] dev_select_i
);

  localparam logic [CntW-1:0] MaxOutCnt = CntW'(MaxOutstanding);
  localparam logic [NWD-1:0]  ErrSel    = NWD'(N);

  logic [CntW-1:0] r_num_outstanding;
  logic [NWD-1:0]  r_dev_select_outstanding;
  logic            w_hold;
  logic            w_sel_a_ready;
  logic            w_accept;
  logic            w_complete;
  tl_h2d_t         w_err_req;
  tl_d2h_t         w_err_rsp;
  tl_d2h_t         w_rsp;

  // Stall when switching targets with traffic in flight, or when the tracker is full.
  always_comb begin
    w_hold = ((r_num_outstanding != '0) && (dev_select_i != r_dev_select_outstanding)) ||
             (r_num_outstanding == MaxOutCnt);
  end

  // Fan the host request out; only the selected, unheld target sees a_valid.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      tl_d_o[i]         = tl_h_i;
      tl_d_o[i].a_valid = tl_h_i.a_valid & (dev_select_i == NWD'(i)) & ~w_hold;
      tl_d_o[i].d_ready = tl_h_i.d_ready & (r_dev_select_outstanding == NWD'(i));
    end
    w_err_req         = tl_h_i;
    w_err_req.a_valid = tl_h_i.a_valid & (dev_select_i >= ErrSel) & ~w_hold;
    w_err_req.d_ready = tl_h_i.d_ready & (r_dev_select_outstanding >= ErrSel);
  end

  // Pick a_ready from the requested target and the response from the outstanding one.
  always_comb begin
    w_sel_a_ready = w_err_rsp.a_ready;
    w_rsp         = w_err_rsp;
    for (int unsigned i = 0; i < N; i++) begin
      w_sel_a_ready = (dev_select_i == NWD'(i)) ? tl_d_i[i].a_ready : w_sel_a_ready;
      w_rsp         = (r_dev_select_outstanding == NWD'(i)) ? tl_d_i[i] : w_rsp;
    end
    tl_h_o         = w_rsp;
    tl_h_o.a_ready = w_sel_a_ready & ~w_hold;
    w_accept       = tl_h_i.a_valid & w_sel_a_ready & ~w_hold;
    w_complete     = w_rsp.d_valid & tl_h_i.d_ready;
  end

  // Remember the active target and count in-flight requests; stale responses after reset are not counted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_num_outstanding        <= '0;
      r_dev_select_outstanding <= '0;
    end else begin
      if (w_accept) begin
        r_dev_select_outstanding <= dev_select_i;
      end else begin
        r_dev_select_outstanding <= r_dev_select_outstanding;
      end
      case ({w_accept, w_complete})
        2'b10:   r_num_outstanding <= r_num_outstanding + CntW'(1);
        2'b01:   r_num_outstanding <= (r_num_outstanding != '0) ? r_num_outstanding - CntW'(1)
                                                                 : r_num_outstanding;
        default: r_num_outstanding <= r_num_outstanding;
      endcase
    end
  end

  tlul_err_resp u_err_resp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tl_h_i (w_err_req),
    .tl_h_o (w_err_rsp)
  );

endmodule

// File: tb/tb_tlul_socket_1n.sv
// Scoreboard bench for tlul_socket_1n: directed requests push expected host responses,
// a monitor pops and compares every host D-channel handshake.
module tb_tlul_socket_1n;
  import tlul_pkg::*;

  logic       clk;
  logic       rst_n;
  tl_h2d_t    tl_h_i;
  tl_d2h_t    tl_h_o;
  tl_h2d_t    tl_d_o [4];
  tl_d2h_t    tl_d_i [4];
  logic [2:0] dev_sel;

  int n_checks = 0;
  int n_errors = 0;

  logic [49:0] exp_q [$];
  logic [3:0]  dev_rsp_en;
  logic [3:0]  dev_a_ready;
  tl_d2h_t     dev_mem [4][16];
  int          dev_wp [4];
  int          dev_rp [4];
  int          av_cnt [4];

  tlul_socket_1n #(.N(4), .MaxOutstanding(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tl_h_i       (tl_h_i),
    .tl_h_o       (tl_h_o),
    .tl_d_o       (tl_d_o),
    .tl_d_i       (tl_d_i),
    .dev_select_i (dev_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [49:0] rsp_vec(input tl_d2h_t r);
    return {3'(r.d_opcode), r.d_param, r.d_size, r.d_source, r.d_sink, r.d_data, r.d_error};
  endfunction

  task automatic push_exp(input logic [2:0] op, input logic [31:0] data, input logic [7:0] src,
                          input logic [1:0] sz, input logic err);
    exp_q.push_back({op, 3'h0, sz, src, 1'b0, data, err});
  endtask

  // Simple device: acks in order, Get data = {16'hCAFE, address[15:0]}.
  function automatic tl_d2h_t dev_rsp(input tl_h2d_t req);
    tl_d2h_t r;
    r          = TL_D2H_DEFAULT;
    r.d_valid  = 1'b1;
    r.d_opcode = (req.a_opcode == Get) ? AccessAckData : AccessAck;
    r.d_size   = req.a_size;
    r.d_source = req.a_source;
    r.d_data   = (req.a_opcode == Get) ? {16'hCAFE, req.a_address[15:0]} : 32'h0;
    return r;
  endfunction

  // Device models: queue a response per accepted request, pop on D handshake.
  always @(posedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (!rst_n) begin
        dev_wp[d] <= 0;
        dev_rp[d] <= 0;
      end else begin
        if (tl_d_i[d].d_valid && tl_d_o[d].d_ready) dev_rp[d] <= dev_rp[d] + 1;
        if (tl_d_o[d].a_valid && tl_d_i[d].a_ready) begin
          dev_mem[d][dev_wp[d] % 16] <= dev_rsp(tl_d_o[d]);
          dev_wp[d] <= dev_wp[d] + 1;
        end
      end
    end
  end

  // Present each device's head response.
  always_comb begin
    for (int d = 0; d < 4; d++) begin
      tl_d_i[d]         = dev_mem[d][dev_rp[d] % 16];
      tl_d_i[d].d_valid = dev_rsp_en[d] && (dev_wp[d] != dev_rp[d]);
      tl_d_i[d].a_ready = dev_a_ready[d];
    end
  end

  // Count cycles each device sees a_valid.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (tl_d_o[d].a_valid) av_cnt[d] <= av_cnt[d] + 1;
    end
  end

  // Monitor: compare each host response handshake, and check stability under back-pressure.
  logic        stall_prev = 1'b0;
  logic [49:0] stall_vec;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else if (tl_h_o.d_valid && !tl_h_i.d_ready) begin
      if (stall_prev) check("d_stable", 64'(rsp_vec(tl_h_o)), 64'(stall_vec));
      stall_prev = 1'b1;
      stall_vec  = rsp_vec(tl_h_o);
    end else begin
      stall_prev = 1'b0;
      if (tl_h_o.d_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_vec(tl_h_o)), 64'h0);
        end else begin
          check("d_rsp", 64'(rsp_vec(tl_h_o)), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic drive_req(input logic [2:0] sel, input tl_a_op_e op, input logic [31:0] addr,
                           input logic [7:0] src, input logic [1:0] sz);
    tl_h_i.a_valid   = 1'b1;
    tl_h_i.a_opcode  = op;
    tl_h_i.a_address = addr;
    tl_h_i.a_source  = src;
    tl_h_i.a_size    = sz;
    tl_h_i.a_mask    = 4'hF;
    tl_h_i.a_data    = {24'h123400, src};
    dev_sel          = sel;
  endtask

  task automatic wait_accept(input string name, input int budget, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (tl_h_o.a_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        waited++;
      end
    end
    tl_h_i.a_valid = 1'b0;
    check({name, "_accepted"}, 64'(ok), 64'd1);
  endtask

  task automatic send(input string name, input logic [2:0] sel, input tl_a_op_e op,
                      input logic [31:0] addr, input logic [7:0] src, input logic [1:0] sz,
                      output int waited);
    drive_req(sel, op, addr, src, sz);
    wait_accept(name, 8, waited);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  int waited;
  int av0 [4];

  initial begin
    tl_h_i      = TL_H2D_DEFAULT;
    dev_sel     = 3'd0;
    dev_rsp_en  = 4'hF;
    dev_a_ready = 4'hF;
    for (int d = 0; d < 4; d++) av_cnt[d] = 0;
    rst_n = 1'b0;

    // Reset state
    #2;
    check("rst_cnt", 64'(dut.r_num_outstanding), 64'd0);
    check("rst_sel", 64'(dut.r_dev_select_outstanding), 64'd0);
    check("rst_dev_avalid", 64'({tl_d_o[3].a_valid, tl_d_o[2].a_valid, tl_d_o[1].a_valid, tl_d_o[0].a_valid}), 64'd0);
    check("rst_h_dvalid", 64'(tl_h_o.d_valid), 64'd0);
    check("rst_err_pending", 64'(dut.u_err_resp.r_pending), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: single Get to device 2
    for (int d = 0; d < 4; d++) av0[d] = av_cnt[d];
    push_exp(3'h1, 32'hCAFE_0001, 8'h11, 2'd2, 1'b0);
    send("t1_get", 3'd2, Get, 32'h1, 8'h11, 2'd2, waited);
    check("t1_cnt_one", 64'(dut.r_num_outstanding), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("t1_cnt_zero", 64'(dut.r_num_outstanding), 64'd0);
    check("t1_avalid_only_dev2",
          64'({8'(av_cnt[3] - av0[3]), 8'(av_cnt[2] - av0[2]), 8'(av_cnt[1] - av0[1]), 8'(av_cnt[0] - av0[0])}),
          64'h0001_0000);
    wait_drain("t1", 10);

    // T2: fill tracker with 8 Puts to device 1
    dev_rsp_en[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      push_exp(3'h0, 32'h0, 8'(k), 2'd2, 1'b0);
      send("t2_put", 3'd1, PutFullData, 32'h10, 8'(k), 2'd2, waited);
    end
    check("t2_cnt_full", 64'(dut.r_num_outstanding), 64'd8);
    push_exp(3'h0, 32'h0, 8'd8, 2'd2, 1'b0);
    drive_req(3'd1, PutFullData, 32'h10, 8'd8, 2'd2);
    repeat (3) begin
      @(negedge clk);
      check("t2_full_ready", 64'(tl_h_o.a_ready), 64'd0);
      check("t2_full_dev_avalid", 64'(tl_d_o[1].a_valid), 64'd0);
    end
    @(posedge clk); #1;
    dev_rsp_en[1] = 1'b1;
    @(posedge clk); #1;
    dev_rsp_en[1] = 1'b0;
    wait_accept("t2_ninth", 2, waited);
    check("t2_ninth_wait", 64'(waited), 64'd0);
    check("t2_cnt_refull", 64'(dut.r_num_outstanding), 64'd8);
    push_exp(3'h0, 32'h0, 8'd9, 2'd2, 1'b0);
    drive_req(3'd1, PutFullData, 32'h10, 8'd9, 2'd2);
    repeat (2) begin
      @(negedge clk);
      check("t2_tenth_held", 64'(tl_h_o.a_ready), 64'd0);
    end
    @(posedge clk); #1;
    dev_rsp_en[1] = 1'b1;
    wait_accept("t2_tenth", 20, waited);
    wait_drain("t2", 40);
    check("t2_cnt_zero", 64'(dut.r_num_outstanding), 64'd0);

    // T3: switching target is held until the old target completes
    dev_rsp_en[0] = 1'b0;
    push_exp(3'h1, 32'hCAFE_0004, 8'h20, 2'd2, 1'b0);
    send("t3_dev0", 3'd0, Get, 32'h4, 8'h20, 2'd2, waited);
    push_exp(3'h0, 32'h0, 8'h21, 2'd2, 1'b0);
    drive_req(3'd3, PutPartialData, 32'h8, 8'h21, 2'd2);
    repeat (3) begin
      @(negedge clk);
      check("t3_held_ready", 64'(tl_h_o.a_ready), 64'd0);
      check("t3_held_dev3_avalid", 64'(tl_d_o[3].a_valid), 64'd0);
    end
    @(posedge clk); #1;
    dev_rsp_en[0] = 1'b1;
    wait_accept("t3_dev3", 5, waited);
    wait_drain("t3", 10);

    // T4: error responder, Get then unknown opcode back-to-back
    push_exp(3'h1, 32'hFFFF_FFFF, 8'h5A, 2'd2, 1'b1);
    send("t4_err_get", 3'd4, Get, 32'h100, 8'h5A, 2'd2, waited);
    @(negedge clk);
    check("t4_err_dvalid", 64'(tl_h_o.d_valid), 64'd1);
    @(posedge clk); #1;
    push_exp(3'h0, 32'h0, 8'h5B, 2'd1, 1'b1);
    send("t4_err_unk", 3'd4, tl_a_op_e'(3'h7), 32'h104, 8'h5B, 2'd1, waited);
    check("t4_err_unk_wait", 64'(waited), 64'd0);
    push_exp(3'h0, 32'h0, 8'h5C, 2'd2, 1'b1);
    drive_req(3'd4, PutFullData, 32'h108, 8'h5C, 2'd2);
    wait_accept("t4_err_b2b", 8, waited);
    check("t4_err_b2b_wait", 64'(waited), 64'd1);
    wait_drain("t4", 10);

    // T5: accept and complete together at count 3, then back-pressure
    dev_rsp_en[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push_exp(3'h0, 32'h0, 8'(8'h30 + k), 2'd2, 1'b0);
      send("t5_put", 3'd2, PutFullData, 32'h20, 8'(8'h30 + k), 2'd2, waited);
    end
    check("t5_cnt3", 64'(dut.r_num_outstanding), 64'd3);
    dev_rsp_en[2] = 1'b1;
    push_exp(3'h0, 32'h0, 8'h33, 2'd2, 1'b0);
    drive_req(3'd2, PutFullData, 32'h20, 8'h33, 2'd2);
    @(negedge clk);
    check("t5_both_handshake", 64'({tl_h_o.a_ready, tl_h_o.d_valid}), 64'h3);
    @(posedge clk); #1;
    tl_h_i.a_valid = 1'b0;
    dev_rsp_en[2]  = 1'b0;
    check("t5_cnt_stays3", 64'(dut.r_num_outstanding), 64'd3);
    tl_h_i.d_ready = 1'b0;
    dev_rsp_en[2]  = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_bp_head", 64'({tl_h_o.d_valid, tl_h_o.d_source}), 64'h131);
    @(posedge clk); #1;
    tl_h_i.d_ready = 1'b1;
    wait_drain("t5", 10);
    check("t5_cnt_zero", 64'(dut.r_num_outstanding), 64'd0);

    // T6a: reset with 5 outstanding
    dev_rsp_en[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send("t6_put", 3'd3, PutFullData, 32'h30, 8'(8'h40 + k), 2'd2, waited);
    end
    check("t6_cnt5", 64'(dut.r_num_outstanding), 64'd5);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_cnt", 64'(dut.r_num_outstanding), 64'd0);
    check("t6_rst_dev_avalid", 64'({tl_d_o[3].a_valid, tl_d_o[2].a_valid, tl_d_o[1].a_valid, tl_d_o[0].a_valid}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dev_rsp_en[3] = 1'b1;

    // T6b: reset with the error responder pending
    tl_h_i.d_ready = 1'b0;
    send("t6_err", 3'd4, Get, 32'h200, 8'h77, 2'd2, waited);
    @(negedge clk);
    check("t6_err_pending_dvalid", 64'(tl_h_o.d_valid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_h_dvalid", 64'(tl_h_o.d_valid), 64'd0);
    check("t6_rst_err_pending", 64'(dut.u_err_resp.r_pending), 64'd0);
    check("t6_rst_cnt2", 64'(dut.r_num_outstanding), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tl_h_i.d_ready = 1'b1;

    // Recovery after reset
    push_exp(3'h1, 32'hCAFE_0002, 8'h01, 2'd2, 1'b0);
    send("t7_get", 3'd1, Get, 32'h2, 8'h01, 2'd2, waited);
    wait_drain("t7", 10);
    check("t7_cnt_zero", 64'(dut.r_num_outstanding), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
